// File: rtl/rf_write_queue_if.sv
// rf_write_queue_if: writeback-to-queue request, RF write port and bypass lookup bundle
interface rf_write_queue_if #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 4
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic          Flush, InValid, InReady, DrainEn, WriteReg, Empty, LkHit1, LkHit2;
  logic [AW-1:0] InReg, DstReg, LkReg1, LkReg2;
  logic [DW-1:0] InData, DstData, LkData1, LkData2;
  logic [CW-1:0] Count;
  modport master (
    output Flush, InValid, InReg, InData, DrainEn, LkReg1, LkReg2,
    input  InReady, WriteReg, DstReg, DstData, Empty, Count, LkHit1, LkData1, LkHit2, LkData2
  );
  modport slave (
    input  Flush, InValid, InReg, InData, DrainEn, LkReg1, LkReg2,
    output InReady, WriteReg, DstReg, DstData, Empty, Count, LkHit1, LkData1, LkHit2, LkData2
  );
endinterface

// File: rtl/rf_write_queue.sv
// rf_write_queue: in-order register write buffer draining onto the RF write port; RFWQ_BYPASS_EN enables pending-value lookups
module rf_write_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 4
) (
  input logic             clk,
  input logic             rst,
  rf_write_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_reg  [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic          w_full, w_empty, w_push, w_pop;
  assign w_full  = r_count == CW'(DEPTH);
  assign w_empty = r_count == '0;
  // writes to register 0 complete the handshake but are dropped
  assign w_push  = bus.InValid & ~w_full & ~bus.Flush & (bus.InReg != '0);
  assign w_pop   = bus.DrainEn & ~w_empty & ~bus.Flush;
  assign bus.InReady  = ~w_full;
  assign bus.Empty    = w_empty;
  assign bus.Count    = r_count;
  assign bus.WriteReg = w_pop;
  assign bus.DstReg   = w_empty ? '0 : r_reg[r_head];
  assign bus.DstData  = w_empty ? '0 : r_data[r_head];
  // pointers and occupancy; flush returns to the reset state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.Flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + PW'(w_push);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  // entry storage needs no reset: entries outside head..tail are never observed
  always_ff @(posedge clk)
    if (w_push) begin
      r_reg[r_tail]  <= bus.InReg;
      r_data[r_tail] <= bus.InData;
    end
`ifdef RFWQ_BYPASS_EN
  // walk oldest to youngest so the youngest match is the one left standing
  function automatic logic [DW:0] f_lookup(input logic [AW-1:0] a);
    logic [PW-1:0] p;
    f_lookup = '0;
    for (int i = 0; i < DEPTH; i++) begin
      p = r_head + PW'(i);
      if (CW'(i) < r_count && a != '0 && r_reg[p] == a) f_lookup = {1'b1, r_data[p]};
    end
  endfunction
  assign {bus.LkHit1, bus.LkData1} = f_lookup(bus.LkReg1);
  assign {bus.LkHit2, bus.LkData2} = f_lookup(bus.LkReg2);
`else
  assign bus.LkHit1  = 1'b0;
  assign bus.LkData1 = '0;
  assign bus.LkHit2  = 1'b0;
  assign bus.LkData2 = '0;
`endif
endmodule

// File: tb/tb_rf_write_queue.sv
// tb_rf_write_queue: directed steps with a write-order scoreboard for rf_write_queue
module tb_rf_write_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int AW    = 4;
`ifdef RFWQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  logic [AW+DW-1:0] sb [$];
  rf_write_queue_if #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) bus ();
  rf_write_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
    bus.InValid = v;
    bus.InReg   = r;
    bus.InData  = d;
  endtask
  // one clock: score the RF write and the accepted push seen before the edge, then step past it
  task automatic tick();
    logic [AW+DW-1:0] e;
    @(negedge clk);
    if (bus.Flush) sb.delete();
    else begin
      if (bus.WriteReg) begin
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("drain_reg", 32'(bus.DstReg), 32'(e[AW+DW-1:DW]));
          check("drain_data", 32'(bus.DstData), 32'(e[DW-1:0]));
        end
      end
      if (bus.InValid && bus.InReady && bus.InReg != '0) sb.push_back({bus.InReg, bus.InData});
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    drive(1'b0, '0, '0);
    bus.DrainEn = 1'b1;
    for (int i = 0; i < 8 && !bus.Empty; i++) tick();
    bus.DrainEn = 1'b0;
    #1;
    check("drained_empty", 32'(bus.Empty), 32'd1);
    check("drained_sb", 32'(sb.size()), 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    bus.Flush = 1'b0;
    bus.DrainEn = 1'b0;
    bus.LkReg1 = '0;
    bus.LkReg2 = '0;
    drive(1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_writereg", 32'(bus.WriteReg), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_empty", 32'(bus.Empty), 32'd1);
    check("rst_inready", 32'(bus.InReady), 32'd1);
    check("rst_count", 32'(bus.Count), 32'd0);
    check("rst_dstreg", 32'(bus.DstReg), 32'd0);
    check("rst_dstdata", 32'(bus.DstData), 32'h0000);
    check("rst_lkhit1", 32'(bus.LkHit1), 32'd0);
    // two queued writes drain in order, one per cycle
    drive(1'b1, 4'd2, 16'h03FE);
    tick();
    drive(1'b1, 4'd13, 16'hDDDD);
    tick();
    drive(1'b0, '0, '0);
    #1;
    check("two_count", 32'(bus.Count), 32'd2);
    check("two_hold_writereg", 32'(bus.WriteReg), 32'd0);
    bus.DrainEn = 1'b1;
    #1;
    check("two_first_reg", 32'(bus.DstReg), 32'd2);
    check("two_first_we", 32'(bus.WriteReg), 32'd1);
    tick();
    check("two_second_data", 32'(bus.DstData), 32'hDDDD);
    tick();
    check("two_empty", 32'(bus.Empty), 32'd1);
    check("two_empty_we", 32'(bus.WriteReg), 32'd0);
    check("two_empty_data", 32'(bus.DstData), 32'h0000);
    bus.DrainEn = 1'b0;
    // fill to capacity, refuse a fifth push, then push while popping
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, AW'(i), DW'(16'hA000 + i));
      tick();
    end
    check("full_inready", 32'(bus.InReady), 32'd0);
    check("full_count", 32'(bus.Count), 32'd4);
    drive(1'b1, 4'd5, 16'h5555);
    tick();
    check("full_refused_count", 32'(bus.Count), 32'd4);
    bus.DrainEn = 1'b1;
    #1;
    check("full_pop_inready", 32'(bus.InReady), 32'd0);
    tick();
    check("full_pop_refused_push", 32'(bus.Count), 32'd3);
    tick();
    check("pushpop_count_same", 32'(bus.Count), 32'd3);
    bus.DrainEn = 1'b0;
    drive(1'b1, 4'd6, 16'h6666);
    tick();
    check("refill_count", 32'(bus.Count), 32'd4);
    drain();
    // bypass: youngest match wins, register 0 never queued nor hit
    drive(1'b1, 4'd13, 16'hDDDD);
    tick();
    drive(1'b1, 4'd13, 16'hDDFF);
    tick();
    drive(1'b0, '0, '0);
    bus.LkReg2 = 4'd13;
    bus.LkReg1 = 4'd7;
    #1;
    check("lk2_hit", 32'(bus.LkHit2), 32'(BYP));
    check("lk2_data", 32'(bus.LkData2), BYP ? 32'hDDFF : 32'h0);
    check("lk1_miss", 32'(bus.LkHit1), 32'd0);
    drive(1'b1, 4'd0, 16'h1234);
    #1;
    check("r0_inready", 32'(bus.InReady), 32'd1);
    tick();
    drive(1'b0, '0, '0);
    bus.LkReg1 = 4'd0;
    #1;
    check("r0_count", 32'(bus.Count), 32'd2);
    check("r0_lk1_hit", 32'(bus.LkHit1), 32'd0);
    bus.DrainEn = 1'b1;
    #1;
    check("lk_popping_hit", 32'(bus.LkHit2), 32'(BYP));
    tick();
    check("lk_after_pop_data", 32'(bus.LkData2), BYP ? 32'hDDFF : 32'h0);
    bus.LkReg2 = '0;
    drain();
    // flush overrides simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, AW'(6 + i), DW'(16'h0600 + i));
      tick();
    end
    drive(1'b1, 4'd9, 16'h9999);
    bus.DrainEn = 1'b1;
    bus.Flush = 1'b1;
    #1;
    check("flush_we", 32'(bus.WriteReg), 32'd0);
    tick();
    bus.Flush = 1'b0;
    bus.DrainEn = 1'b0;
    drive(1'b0, '0, '0);
    #1;
    check("flush_count", 32'(bus.Count), 32'd0);
    check("flush_empty", 32'(bus.Empty), 32'd1);
    // asynchronous reset mid-drain clears the port before any edge
    drive(1'b1, 4'd10, 16'hAAAA);
    tick();
    drive(1'b1, 4'd11, 16'hBBBB);
    tick();
    drive(1'b0, '0, '0);
    bus.DrainEn = 1'b1;
    #1;
    check("arst_pre_we", 32'(bus.WriteReg), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_empty", 32'(bus.Empty), 32'd1);
    check("arst_we", 32'(bus.WriteReg), 32'd0);
    check("arst_count", 32'(bus.Count), 32'd0);
    sb.delete();
    bus.DrainEn = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("arst_stays_empty", 32'(bus.Empty), 32'd1);
    check("final_sb", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
